aes_key_expansion: RTL and testbench
====================================

Name: aes_key_expansion

Overview:
Iterative AES key-schedule engine, generalised over key length (128/192/256).
- Captures a cipher key, generates one 32-bit schedule word per clock and stores the complete schedule (Nr+1 round keys).
- Serves round keys through a registered read port.
- Sits between the key-loading interface and the round datapath; the round engine fetches one round key per round by index.

Parameters:
KEY_L, 128, cipher key length in bits; legal values are 128, 192 and 256; any other value is an elaboration error.
DATA_W, 128, block/round-key width; fixed at 128, other values are an elaboration error.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
valid_in  input  1  cipher_key valid, single-cycle strobe
cipher_key  input  KEY_L  cipher key, FIPS-197 byte order (MSB = byte 0)
busy  output  1  expansion in progress
key_ready  output  1  full schedule valid
rk_idx  input  4  round-key index, 0..Nr
round_key  output  DATA_W  round key rk_idx, registered

Behaviour:
- Derived constants:
  - Nk = KEY_L/32 (4/6/8).
  - Nr = Nk+6 (10/12/14).
  - Ntot = 4*(Nr+1) (44/52/60) words.
  - Storage is Ntot x 32-bit flops.
- Reset (asynchronous, reset_n low): state IDLE, busy=0, key_ready=0, round_key=0, word counter=0, all storage cleared. Reset mid-expansion aborts with the same values; no partial schedule survives.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE or DONE, valid_in=1 at edge E0:
    - words w[0..Nk-1] are loaded from cipher_key (w[0] = cipher_key[KEY_L-1 -: 32]);
    - counter i=Nk; go to EXPAND; busy=1, key_ready=0 from E0.
  - EXPAND: each edge writes w[i] = w[i-Nk] ^ temp, then i++, where temp is:
    - i mod Nk == 0: SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0}.
    - Nk==8 and i mod 8 == 4: SubWord(w[i-1]).
    - otherwise: w[i-1].
  - EXPAND ends on the edge writing w[Ntot-1]: go to DONE, busy=0, key_ready=1.
- Latency:
  - key_ready rises at E0+(Ntot-Nk): 40/46/52 edges for 128/192/256.
  - busy is high for exactly that many cycles.
- valid_in during EXPAND is ignored; the key is not captured and there is no restart.
- valid_in in DONE restarts expansion; key_ready falls at the capture edge.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36; computed by xtime chain or 10-entry ROM.
- SubWord uses four instances of the existing combinational byte S-box aes_sbox.
- Read port:
  - round_key <= {w[4k],w[4k+1],w[4k+2],w[4k+3]} for k=rk_idx, one cycle after rk_idx is presented.
  - round_key <= 0 when key_ready=0 or rk_idx>Nr.
  - round_key updates every cycle (no enable).
- Simultaneous valid_in and a read in DONE: the read returns 0 (key_ready already low on the next cycle).

Optional Feature:
KEXP_ZEROIZE_EN
- Defined:
  - adds input port zeroize (1 bit, after rk_idx).
  - zeroize=1 at an edge clears all storage, counter and round_key, forces IDLE, busy=0, key_ready=0.
  - zeroize has priority over valid_in in the same cycle and acts in any state.
- Undefined: the port is absent; storage retains the last schedule until reset or a new key.

Test Plan:
1. KEY_L=128, key 2b7e151628aed2a6abf7158809cf4f3c, pulse valid_in -> busy for 40 cycles; key_ready at E0+40; rk_idx=1 gives w[4]=a0fafe17; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
2. KEY_L=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_ready at E0+46; w[6]=fe0c91f7; w[51]=01002202 (last word of rk_idx=12).
3. KEY_L=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_ready at E0+52; w[8]=9ba35411; w[59]=706c631e.
4. KEY_L=128, second valid_in 10 cycles into expansion -> ignored; schedule matches test 1. Then new key in DONE -> key_ready low at capture, reads return 0 until the new schedule completes.
5. Assert reset_n low at cycle 20 of expansion -> all outputs 0 immediately, state IDLE. rk_idx=11 in DONE (KEY_L=128) -> round_key=0.
6. With KEXP_ZEROIZE_EN: zeroize and valid_in in the same cycle in DONE -> IDLE, key_ready=0, all reads 0, no expansion starts.

Source files
------------

// File: rtl/aes_key_expansion.sv
// Iterative AES key schedule (128/192/256-bit keys): one 32-bit word per clock,
// full schedule held in flops and served through a registered round-key port.
// Optional build macro KEXP_ZEROIZE_EN adds a zeroize input that wipes the schedule.

module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
      return gf_mul(r, r);
   endfunction

   logic [7:0] inv_byte;

   always_comb begin
      inv_byte = gf_inv(in_byte);
      out_byte = inv_byte
               ^ {inv_byte[6:0], inv_byte[7]}
               ^ {inv_byte[5:0], inv_byte[7:6]}
               ^ {inv_byte[4:0], inv_byte[7:5]}
               ^ {inv_byte[3:0], inv_byte[7:4]}
               ^ 8'h63;
   end

endmodule

module aes_key_expansion #(
   parameter int KEY_L  = 128,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_in,
   input  logic [KEY_L-1:0]  cipher_key,
   output logic              busy,
   output logic              key_ready,
   input  logic [3:0]        rk_idx,
`ifdef KEXP_ZEROIZE_EN
   input  logic              zeroize,
`endif
   output logic [DATA_W-1:0] round_key
);

   localparam int NK   = KEY_L / 32;
   localparam int NR   = NK + 6;
   localparam int NTOT = 4 * (NR + 1);

   if (!(KEY_L == 128 || KEY_L == 192 || KEY_L == 256)) begin : g_bad_key_l
      $error("aes_key_expansion: KEY_L must be 128, 192 or 256");
   end
   if (DATA_W != 128) begin : g_bad_data_w
      $error("aes_key_expansion: DATA_W must be 128");
   end

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        w_q [NTOT];
   logic [31:0]        w_d [NTOT];
   logic [5:0]         cnt_q, cnt_d;
   logic [2:0]         phase_q, phase_d;
   logic [7:0]         rcon_q, rcon_d;
   logic [DATA_W-1:0]  round_key_q, round_key_d;

   logic [5:0]         prev_idx;
   logic [5:0]         old_idx;
   logic [31:0]        prev_word;
   logic [31:0]        sub_in;
   logic [31:0]        sub_out;
   logic [31:0]        temp_word;
   logic [3:0]         rk_sel;
   logic [5:0]         rk_base;
   logic               zero_req;

`ifdef KEXP_ZEROIZE_EN
   assign zero_req = zeroize;
`else
   assign zero_req = 1'b0;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   // phase_q tracks i mod Nk so no divider is needed for 192-bit keys
   always_comb begin
      prev_idx  = cnt_q - 6'd1;
      old_idx   = cnt_q - 6'(NK);
      prev_word = w_q[prev_idx];
      sub_in    = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      if (phase_q == 3'd0) begin
         temp_word = sub_out ^ {rcon_q, 24'h0};
      end else if (NK == 8 && phase_q == 3'd4) begin
         temp_word = sub_out;
      end else begin
         temp_word = prev_word;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (sub_in[8*g +: 8]),
         .out_byte (sub_out[8*g +: 8])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      rcon_d  = rcon_q;
      w_d     = w_q;
      if (zero_req) begin
         state_d = IDLE;
         cnt_d   = '0;
         phase_d = '0;
         rcon_d  = '0;
         for (int j = 0; j < NTOT; j++) w_d[j] = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (valid_in) begin
                  for (int j = 0; j < NK; j++) w_d[j] = cipher_key[KEY_L-1-32*j -: 32];
                  cnt_d   = 6'(NK);
                  phase_d = '0;
                  rcon_d  = 8'h01;
                  state_d = EXPAND;
               end
            end
            EXPAND: begin
               w_d[cnt_q] = w_q[old_idx] ^ temp_word;
               cnt_d      = cnt_q + 6'd1;
               phase_d    = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
               if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
               if (cnt_q == 6'(NTOT - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A read only returns data if the schedule is complete now and stays complete
   always_comb begin
      rk_sel  = (rk_idx > 4'(NR)) ? 4'd0 : rk_idx;
      rk_base = {rk_sel, 2'b00};
      if (state_q == DONE && state_d == DONE && rk_idx <= 4'(NR)) begin
         round_key_d = {w_q[rk_base], w_q[rk_base + 6'd1],
                        w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
      end else begin
         round_key_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         phase_q     <= '0;
         rcon_q      <= '0;
         round_key_q <= '0;
         for (int j = 0; j < NTOT; j++) w_q[j] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         rcon_q      <= rcon_d;
         round_key_q <= round_key_d;
         w_q         <= w_d;
      end
   end

   assign busy      = (state_q == EXPAND);
   assign key_ready = (state_q == DONE);
   assign round_key = round_key_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: one instance per key length,
// a behavioural key-schedule model, and FIPS-197 literal vectors.

module tb_aes_key_expansion;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KC1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK10_K128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK10_KC1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         valid_r [3];
   logic [255:0] key_r   [3];
   logic [3:0]   idx_r   [3];
   logic         zero_r  [3];
   logic         busy_o  [3];
   logic         ready_o [3];
   logic [127:0] rk_o    [3];

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb    [256];
   logic [31:0]  m_w   [4][60];
   logic         m_busy  [3];
   logic         m_ready [3];
   int           m_rem   [3];
   logic [127:0] m_rk    [3];

   always #5 clk = ~clk;

   aes_key_expansion #(.KEY_L(128), .DATA_W(128)) u_dut128 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_r[0]), .cipher_key(key_r[0][255:128]),
      .busy(busy_o[0]), .key_ready(ready_o[0]), .rk_idx(idx_r[0]),
`ifdef KEXP_ZEROIZE_EN
      .zeroize(zero_r[0]),
`endif
      .round_key(rk_o[0]));

   aes_key_expansion #(.KEY_L(192), .DATA_W(128)) u_dut192 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_r[1]), .cipher_key(key_r[1][255:64]),
      .busy(busy_o[1]), .key_ready(ready_o[1]), .rk_idx(idx_r[1]),
`ifdef KEXP_ZEROIZE_EN
      .zeroize(zero_r[1]),
`endif
      .round_key(rk_o[1]));

   aes_key_expansion #(.KEY_L(256), .DATA_W(128)) u_dut256 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_r[2]), .cipher_key(key_r[2]),
      .busy(busy_o[2]), .key_ready(ready_o[2]), .rk_idx(idx_r[2]),
`ifdef KEXP_ZEROIZE_EN
      .zeroize(zero_r[2]),
`endif
      .round_key(rk_o[2]));

   // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] rcon_of(input int n);
      case (n)
         1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
         5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
         9: return 8'h1b; 10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      for (int b = 0; b < 256; b++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
         sb[b] = s;
      end
   endtask

   task automatic expand_key(input logic [255:0] k, input int nk, input int dst);
      int ntot;
      logic [31:0] t;
      ntot = 4 * (nk + 7);
      for (int i = 0; i < 60; i++) m_w[dst][i] = 32'h0;
      for (int i = 0; i < nk; i++) m_w[dst][i] = k[255-32*i -: 32];
      for (int i = nk; i < ntot; i++) begin
         t = m_w[dst][i-1];
         if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
         else if (nk > 6 && i % nk == 4) t = sub_word(t);
         m_w[dst][i] = m_w[dst][i-nk] ^ t;
      end
   endtask

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Model: a key capture starts a countdown of Ntot-Nk cycles; reads see the
   // finished schedule only while it was complete and no capture is happening.
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         for (int d = 0; d < 3; d++) begin
            m_busy[d] = 1'b0; m_ready[d] = 1'b0; m_rem[d] = 0; m_rk[d] = '0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            int nk;
            int nr;
            int k;
            nk = 4 + 2 * d;
            nr = nk + 6;
            k  = int'(idx_r[d]);
            if (m_ready[d] && !valid_r[d] && !zero_r[d] && k <= nr)
               m_rk[d] = {m_w[d][4*k], m_w[d][4*k+1], m_w[d][4*k+2], m_w[d][4*k+3]};
            else
               m_rk[d] = '0;
            if (zero_r[d]) begin
               m_busy[d] = 1'b0; m_ready[d] = 1'b0; m_rem[d] = 0;
            end else if (!m_busy[d] && valid_r[d]) begin
               expand_key(key_r[d], nk, d);
               m_rem[d]   = 4 * (nr + 1) - nk;
               m_busy[d]  = 1'b1;
               m_ready[d] = 1'b0;
            end else if (m_busy[d]) begin
               m_rem[d]--;
               if (m_rem[d] == 0) begin
                  m_busy[d] = 1'b0; m_ready[d] = 1'b1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check_output($sformatf("busy%0d", d), 128'(busy_o[d]), 128'(m_busy[d]));
         check_output($sformatf("key_ready%0d", d), 128'(ready_o[d]), 128'(m_ready[d]));
         check_output($sformatf("round_key%0d", d), rk_o[d], m_rk[d]);
      end
   end

   task automatic apply_stimulus(input int d, input logic [255:0] k);
      @(posedge clk);
      #2;
      key_r[d]   = k;
      valid_r[d] = 1'b1;
      @(posedge clk);
      #2;
      valid_r[d] = 1'b0;
   endtask

   task automatic wait_ready(input int d, input string name, output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (!ready_o[d] && lat < 200) begin
         if (busy_o[d]) busy_cnt++;
         @(posedge clk);
         #2;
         lat++;
      end
      if (lat >= 200) check_output({name, "_timeout"}, 128'(ready_o[d]), 128'd1);
   endtask

   task automatic run_expansion(input int d, input logic [255:0] k, input int exp_lat, input string name);
      int lat;
      int busy_cnt;
      apply_stimulus(d, k);
      wait_ready(d, name, lat, busy_cnt);
      check_output({name, "_latency"}, 128'(lat), 128'(exp_lat));
      check_output({name, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_lat));
   endtask

   task automatic read_rk(input int d, input logic [3:0] idx, output logic [127:0] val);
      @(posedge clk);
      #2;
      idx_r[d] = idx;
      @(posedge clk);
      #1;
      val = rk_o[d];
   endtask

   initial begin
      logic [127:0] v;
      int lat;
      int busy_cnt;
      reset_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         valid_r[d] = 1'b0; key_r[d] = '0; idx_r[d] = '0; zero_r[d] = 1'b0;
      end
      build_sbox();
      check_output("model_sbox_00", 128'(sb[8'h00]), 128'h63);
      check_output("model_sbox_53", 128'(sb[8'h53]), 128'hed);
      expand_key(K128, 4, 3);
      check_output("model_k128_w4", 128'(m_w[3][4]), 128'ha0fafe17);
      check_output("model_k128_rk10", {m_w[3][40], m_w[3][41], m_w[3][42], m_w[3][43]}, RK10_K128);
      expand_key(KC1, 4, 3);
      check_output("model_kc1_rk10", {m_w[3][40], m_w[3][41], m_w[3][42], m_w[3][43]}, RK10_KC1);
      expand_key(K192, 6, 3);
      check_output("model_k192_w6", 128'(m_w[3][6]), 128'hfe0c91f7);
      check_output("model_k192_w51", 128'(m_w[3][51]), 128'h01002202);
      expand_key(K256, 8, 3);
      check_output("model_k256_w8", 128'(m_w[3][8]), 128'h9ba35411);
      check_output("model_k256_w59", 128'(m_w[3][59]), 128'h706c631e);

      #1;
      check_output("reset_busy", 128'(busy_o[0]), 128'd0);
      check_output("reset_key_ready", 128'(ready_o[0]), 128'd0);
      check_output("reset_round_key", rk_o[0], 128'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      $display("[TB] test 1: 128-bit key");
      run_expansion(0, K128, 40, "t1");
      read_rk(0, 4'd1, v);
      check_output("t1_w4", 128'(v[127:96]), 128'ha0fafe17);
      read_rk(0, 4'd10, v);
      check_output("t1_rk10", v, RK10_K128);

      $display("[TB] test 2: 192-bit key");
      run_expansion(1, K192, 46, "t2");
      read_rk(1, 4'd1, v);
      check_output("t2_w6", 128'(v[63:32]), 128'hfe0c91f7);
      read_rk(1, 4'd12, v);
      check_output("t2_w51", 128'(v[31:0]), 128'h01002202);

      $display("[TB] test 3: 256-bit key");
      run_expansion(2, K256, 52, "t3");
      read_rk(2, 4'd2, v);
      check_output("t3_w8", 128'(v[127:96]), 128'h9ba35411);
      read_rk(2, 4'd14, v);
      check_output("t3_w59", 128'(v[31:0]), 128'h706c631e);

      $display("[TB] test 4: valid_in during expansion, restart in DONE");
      apply_stimulus(0, K128);
      repeat (8) @(posedge clk);
      apply_stimulus(0, KC1);
      wait_ready(0, "t4a", lat, busy_cnt);
      read_rk(0, 4'd10, v);
      check_output("t4_ignored_rk10", v, RK10_K128);
      @(posedge clk);
      #2;
      key_r[0] = KC1; valid_r[0] = 1'b1; idx_r[0] = 4'd10;
      @(posedge clk);
      #1;
      check_output("t4_restart_ready", 128'(ready_o[0]), 128'd0);
      check_output("t4_restart_busy", 128'(busy_o[0]), 128'd1);
      check_output("t4_restart_read", rk_o[0], 128'd0);
      #1;
      valid_r[0] = 1'b0;
      wait_ready(0, "t4b", lat, busy_cnt);
      read_rk(0, 4'd10, v);
      check_output("t4_new_rk10", v, RK10_KC1);

      $display("[TB] test 5: reset mid-expansion, out-of-range index");
      apply_stimulus(0, K128);
      repeat (18) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("t5_busy", 128'(busy_o[0]), 128'd0);
      check_output("t5_key_ready", 128'(ready_o[0]), 128'd0);
      check_output("t5_other_ready", 128'(ready_o[1]), 128'd0);
      check_output("t5_other_round_key", rk_o[1], 128'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      run_expansion(0, K128, 40, "t5");
      read_rk(0, 4'd11, v);
      check_output("t5_rk11", v, 128'd0);
      read_rk(0, 4'd15, v);
      check_output("t5_rk15", v, 128'd0);
      read_rk(0, 4'd0, v);
      check_output("t5_rk0", v, K128[255:128]);

`ifdef KEXP_ZEROIZE_EN
      $display("[TB] test 6: zeroize with valid_in in DONE");
      @(posedge clk);
      #2;
      zero_r[0] = 1'b1; valid_r[0] = 1'b1; key_r[0] = KC1; idx_r[0] = 4'd1;
      @(posedge clk);
      #1;
      check_output("t6_key_ready", 128'(ready_o[0]), 128'd0);
      check_output("t6_busy", 128'(busy_o[0]), 128'd0);
      check_output("t6_round_key", rk_o[0], 128'd0);
      #1;
      zero_r[0] = 1'b0; valid_r[0] = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         check_output("t6_stays_idle", 128'(busy_o[0]), 128'd0);
      end
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
